seq_chunk_alu: RTL and testbench

Multi-cycle, parametrised integer ALU for the y86-64 execute stage. It generalises the 64-bit ripple adder to add, subtract, AND and XOR, and processes operands CHUNK bits per clock, so cycle time is traded against latency. It produces y86 condition codes (ZF, SF, OF) and uses a start/ready/done handshake, so the sequential core can stall on it.

---
 rtl/seq_chunk_alu.sv | 136 +++++++++++++
 tb/tb_seq_chunk_alu.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_alu.sv
// rtl/seq_chunk_alu.sv - multi-cycle chunked add/sub/and/xor ALU with y86 condition codes
//
// Processes WIDTH-bit operands CHUNK bits per clock (NCH = WIDTH/CHUNK cycles).
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - operation request, sampled only while ready=1
//   op     - 00 add, 01 sub, 10 and, 11 xor
//   a, b   - WIDTH-bit two's complement operands
//   ready  - idle, able to accept start
//   done   - one-cycle pulse when result/cc are updated
//   result - WIDTH-bit result, held until the next completion
//   cc     - {ZF, SF, OF}, held until the next completion
module seq_chunk_alu #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       cc
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [1:0]        op_r;
  logic              carry;
  logic [IW-1:0]     idx;
  logic              nz;
  logic [WIDTH-1:0]  acc;

  logic [BW-1:0]     base;
  logic [CHUNK-1:0]  a_i;
  logic [CHUNK-1:0]  b_i;
  logic [CHUNK-1:0]  b_eff;
  logic [CHUNK:0]    sum;
  logic [CHUNK-1:0]  chunk_res;
  logic [WIDTH-1:0]  res_full;
  logic              nz_next;
  logic              last;
  logic              of;

  always_comb begin
    base      = BW'(int'(idx) * CHUNK);
    a_i       = a_r[base +: CHUNK];
    b_i       = b_r[base +: CHUNK];
    // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
    b_eff     = (op_r == OP_SUB) ? ~b_i : b_i;
    sum       = {1'b0, a_i} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry};
    chunk_res = sum[CHUNK-1:0];
    case (op_r)
      OP_AND:  chunk_res = a_i & b_i;
      OP_XOR:  chunk_res = a_i ^ b_i;
      default: chunk_res = sum[CHUNK-1:0];
    endcase
    // acc holds chunks already produced; merge in the current one so the
    // final edge sees the complete result (MSB needed for SF/OF).
    res_full               = acc;
    res_full[base +: CHUNK] = chunk_res;
    nz_next   = nz | (|chunk_res);
    last      = (idx == IW'(NCH - 1));
    case (op_r)
      OP_ADD:  of = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (res_full[WIDTH-1] != a_r[WIDTH-1]);
      OP_SUB:  of = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (res_full[WIDTH-1] != a_r[WIDTH-1]);
      default: of = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      result <= '0;
      cc     <= 3'b000;
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= OP_ADD;
      carry  <= 1'b0;
      idx    <= '0;
      nz     <= 1'b0;
      acc    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            op_r  <= op;
            carry <= (op == OP_SUB);
            idx   <= '0;
            nz    <= 1'b0;
            acc   <= '0;
            ready <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= res_full;
          carry <= sum[CHUNK];
          nz    <= nz_next;
          idx   <= idx + IW'(1);
          if (last) begin
            result <= res_full;
            cc     <= {~nz_next, res_full[WIDTH-1], of};
            done   <= 1'b1;
            ready  <= 1'b1;
            idx    <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_alu.sv
// tb/tb_seq_chunk_alu.sv - directed self-checking bench for seq_chunk_alu
module tb_seq_chunk_alu;

  logic clk;
  logic rst_n;

  // instance 0: defaults (64/16), 1: CHUNK=1, 2: CHUNK=64, 8: WIDTH=8/CHUNK=4
  logic        start0, start1, start2, start8;
  logic [1:0]  op0, op1, op2, op8;
  logic [63:0] a0, b0, a1, b1, a2, b2;
  logic [7:0]  a8, b8;
  logic        ready0, ready1, ready2, ready8;
  logic        done0, done1, done2, done8;
  logic [63:0] result0, result1, result2;
  logic [7:0]  result8;
  logic [2:0]  cc0, cc1, cc2, cc8;

  int vectors;
  int miscompares;

  seq_chunk_alu u_d16 (
    .clk(clk), .rst_n(rst_n), .start(start0), .op(op0), .a(a0), .b(b0),
    .ready(ready0), .done(done0), .result(result0), .cc(cc0)
  );

  seq_chunk_alu #(.WIDTH(64), .CHUNK(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .a(a1), .b(b1),
    .ready(ready1), .done(done1), .result(result1), .cc(cc1)
  );

  seq_chunk_alu #(.WIDTH(64), .CHUNK(64)) u_d64 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op(op2), .a(a2), .b(b2),
    .ready(ready2), .done(done2), .result(result2), .cc(cc2)
  );

  seq_chunk_alu #(.WIDTH(8), .CHUNK(4)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .ready(ready8), .done(done8), .result(result8), .cc(cc8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic st, input logic [1:0] o,
                       input logic [63:0] av, input logic [63:0] bv);
    case (s)
      0: begin start0 = st; op0 = o; a0 = av; b0 = bv; end
      1: begin start1 = st; op1 = o; a1 = av; b1 = bv; end
      default: begin start2 = st; op2 = o; a2 = av; b2 = bv; end
    endcase
  endtask

  task automatic set_start(input int s, input logic st);
    case (s)
      0: start0 = st;
      1: start1 = st;
      default: start2 = st;
    endcase
  endtask

  function automatic logic m_done(input int s);
    case (s)
      0: return done0;
      1: return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic m_ready(input int s);
    case (s)
      0: return ready0;
      1: return ready1;
      default: return ready2;
    endcase
  endfunction

  function automatic logic [63:0] m_res(input int s);
    case (s)
      0: return result0;
      1: return result1;
      default: return result2;
    endcase
  endfunction

  function automatic logic [2:0] m_cc(input int s);
    case (s)
      0: return cc0;
      1: return cc1;
      default: return cc2;
    endcase
  endfunction

  // Called at the negedge following the accepting edge; counts edges until done.
  task automatic wait_done(input int s, input int lat0, output int lat);
    lat = lat0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_done(s) && lat < 300);
  endtask

  task automatic run(input int s, input logic [1:0] o, input logic [63:0] av,
                     input logic [63:0] bv, input logic [63:0] er,
                     input logic [2:0] ec, input int el, input string tag);
    int lat;
    @(negedge clk);
    drive(s, 1'b1, o, av, bv);
    @(negedge clk);
    set_start(s, 1'b0);
    chk({tag, "_busy"}, 64'(m_ready(s)), 64'd0);
    wait_done(s, 0, lat);
    chk({tag, "_latency"}, 64'(lat), 64'(el));
    chk({tag, "_result"}, m_res(s), er);
    chk({tag, "_cc"}, 64'(m_cc(s)), 64'(ec));
    chk({tag, "_ready_at_done"}, 64'(m_ready(s)), 64'd1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(m_done(s)), 64'd0);
    chk({tag, "_hold"}, m_res(s), er);
  endtask

  initial begin
    int lat;
    int seen;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start0 = 0; start1 = 0; start2 = 0; start8 = 0;
    op0 = 0; op1 = 0; op2 = 0; op8 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0; a2 = 0; b2 = 0; a8 = 0; b8 = 0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready0), 64'd1);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_result", result0, 64'd0);
    chk("rst_cc", 64'(cc0), 64'd0);
    chk("rst_w8_ready", 64'(ready8), 64'd1);
    rst_n = 1'b1;

    // arithmetic and logic on the default build
    run(0, 2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
        64'h0, 3'b101, 4, "add_min_min");
    run(0, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
        64'hFFFF_FFFF_FFFF_FFFE, 3'b011, 4, "add_max_max");
    run(0, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
        64'hFFFF_FFFF_FFFF_FFFF, 3'b010, 4, "add_max_min");
    run(0, 2'b01, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010, 4, "sub_5_7");
    run(0, 2'b01, 64'h8000_0000_0000_0000, 64'd1,
        64'h7FFF_FFFF_FFFF_FFFF, 3'b001, 4, "sub_min_1");
    run(0, 2'b01, 64'd4238, 64'd4238, 64'h0, 3'b100, 4, "sub_eq");
    run(0, 2'b10, 64'hF0F0_0000_0000_0000, 64'hFF00_0000_0000_0000,
        64'hF000_0000_0000_0000, 3'b010, 4, "and");
    run(0, 2'b11, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0,
        64'h0, 3'b100, 4, "xor_eq");

    // start pulsed during RUN with new operands is ignored
    @(negedge clk);
    drive(0, 1'b1, 2'b00, 64'd1, 64'd2);
    @(negedge clk);
    drive(0, 1'b0, 2'b00, 64'd1, 64'd2);
    @(negedge clk);
    drive(0, 1'b1, 2'b01, 64'd100, 64'd200);
    @(negedge clk);
    set_start(0, 1'b0);
    wait_done(0, 2, lat);
    chk("ign_latency", 64'(lat), 64'd4);
    chk("ign_result", result0, 64'd3);
    chk("ign_cc", 64'(cc0), 64'd0);

    // start held across done: back-to-back issue
    @(negedge clk);
    drive(0, 1'b1, 2'b00, 64'd1, 64'd1);
    @(negedge clk);
    drive(0, 1'b1, 2'b01, 64'd10, 64'd20);
    wait_done(0, 0, lat);
    chk("b2b_first_latency", 64'(lat), 64'd4);
    chk("b2b_first_result", result0, 64'd2);
    @(negedge clk);
    chk("b2b_accepted", 64'(ready0), 64'd0);
    set_start(0, 1'b0);
    wait_done(0, 0, lat);
    chk("b2b_second_latency", 64'(lat), 64'd4);
    chk("b2b_second_result", result0, 64'hFFFF_FFFF_FFFF_FFF6);
    chk("b2b_second_cc", 64'(cc0), 64'b010);

    // reset during chunk 2
    @(negedge clk);
    drive(0, 1'b1, 2'b00, 64'd3, 64'd4);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_result", result0, 64'd0);
    chk("midrst_cc", 64'(cc0), 64'd0);
    chk("midrst_ready", 64'(ready0), 64'd1);
    chk("midrst_done", 64'(done0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done0) seen++;
    end
    chk("midrst_no_done", 64'(seen), 64'd0);
    run(0, 2'b00, 64'd1, 64'd1, 64'd2, 3'b000, 4, "post_rst");

    // parameter variants
    run(1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
        64'hFFFF_FFFF_FFFF_FFFE, 3'b011, 64, "c1_add");
    run(1, 2'b01, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010, 64, "c1_sub");
    run(2, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
        64'hFFFF_FFFF_FFFF_FFFE, 3'b011, 1, "c64_add");
    run(2, 2'b01, 64'h8000_0000_0000_0000, 64'd1,
        64'h7FFF_FFFF_FFFF_FFFF, 3'b001, 1, "c64_sub");

    @(negedge clk);
    start8 = 1'b1; op8 = 2'b00; a8 = 8'h7F; b8 = 8'h01;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done8 && lat < 300);
    chk("w8_latency", 64'(lat), 64'd2);
    chk("w8_result", 64'(result8), 64'h80);
    chk("w8_cc", 64'(cc8), 64'b011);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
